barrett_modmul_pipe: RTL and testbench
======================================

Name: barrett_modmul_pipe

Overview:
Parametrised, pipelined Barrett modular multiplier for the NTT datapath; computes (a*b) mod q at one result per cycle.
- Modulus q is runtime-programmable through a config port; a sequential divider precomputes mu = floor(2^(2k)/q) after each load.
- Valid/ready streaming with a pass-through tag, so butterfly/NTT controllers can issue back-to-back products and absorb backpressure.

Parameters:
WIDTH, 32, operand/modulus width; q < 2^WIDTH.
TAG_W, 8, width of sideband tag carried alongside each operation.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  request to load new modulus
cfg_q  in  WIDTH  new modulus, 2 <= q < 2^WIDTH
cfg_ready  out  1  config accepted when cfg_valid && cfg_ready
cfg_done  out  1  one-cycle pulse: mu computed, block usable
busy  out  1  high while mu computation in progress
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands
in_a  in  WIDTH  operand a, must be < q
in_b  in  WIDTH  operand b, must be < q
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  WIDTH  (a*b) mod q, always < q
out_tag  out  TAG_W  tag of the same operation

Behaviour:
- Reset: state UNCONF; cfg_ready=1, cfg_done=0, busy=0, in_ready=0, out_valid=0, out_result=0, out_tag=0; all pipeline valids cleared; q, k, mu regs = 0. Reset mid-computation or mid-stream discards everything.
- FSM UNCONF -> CALC on config handshake; CALC -> READY after exactly 2*WIDTH+1 cycles, cfg_done pulses in the first READY cycle; READY -> CALC on config handshake.
- cfg_ready = 1 in UNCONF; in READY only when all pipeline stages and the output register are empty; 0 in CALC. busy = (state==CALC).
- On accept: latch q; k = bit length of q (floor(log2 q)+1, so 2<=k<=WIDTH).
- CALC: bit-serial restoring division of 2^(2k) by q, one dividend bit per cycle over a fixed 2*WIDTH+1 bit window; mu fits in k+1 bits (mu register WIDTH+1 bits).
- in_ready = (state==READY) && adv, where adv = !out_valid || out_ready. The whole pipeline advances only when adv=1; when adv=0 every stage holds, no data lost or duplicated.
- Pipeline, fixed latency 4 accepted-to-out_valid cycles with no stall:
  - S1: z = a*b (2*WIDTH bits).
  - S2: q1 = z >> (k-1); q2 = q1*mu (full width, 2*WIDTH+2 bits).
  - S3: q3 = q2 >> (k+1); t = z - q3*q (t < 3q, computed in WIDTH+2 bits).
  - S4/output reg: conditional subtract q up to twice; result < q.
- Tag travels with its operation; ordering strictly in-order.
- Operands >= q: result unspecified but out_valid/tag timing unchanged.
- cfg_valid while not cfg_ready: ignored, no state change.
- Throughput: one result per cycle while out_ready=1.

Test Plan:
- Reset then load q=3329 -> busy high 65 cycles (WIDTH=32), cfg_done pulse, internal mu=5039, k=12; in_ready rises with cfg_done.
- q=3329, stream (3328,3328), (1234,2345), (0,3328), tags 1,2,3 -> results 1, 829, 0 on consecutive cycles, 4 cycles after the first accept, tags in order.
- Reload q=8380417, input (8380416,8380416) -> result 1; assert cfg_ready=0 while that op is in flight.
- Back-to-back 1000 random in-range pairs, out_ready toggled randomly -> every result matches a golden (a*b)%q, no drops/duplicates, outputs stable while stalled.
- Assert rst_n low mid-CALC and mid-stream -> all outputs return to reset values immediately; block requires reconfiguration (in_ready=0).
- q=2 and q=2^WIDTH-1 with max operands -> results 1 and 1 respectively; cfg_valid during CALC ignored.

Source files
------------

// File: rtl/barrett_modmul_pipe.sv
// rtl/barrett_modmul_pipe.sv - pipelined Barrett modular multiplier with runtime-programmable modulus
module barrett_modmul_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_q,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int KW    = $clog2(WIDTH + 1);
    localparam int CNT_W = KW + 1;
    localparam int ZW    = 2 * WIDTH;
    localparam int PW    = 2 * WIDTH + 2;
    localparam int TW    = WIDTH + 2;

    typedef enum logic [1:0] {UNCONF, CALC, READY} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] q_q;
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    k_new;
    logic [WIDTH:0]   mu_q;
    logic [WIDTH:0]   mu_d;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH:0]   rem_sh;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             cfg_fire;
    logic             calc_last;
    logic             adv;
    logic             pipe_empty;

    logic             v1_q;
    logic [ZW-1:0]    z1_q;
    logic [TAG_W-1:0] tag1_q;
    logic             v2_q;
    logic [TW-1:0]    zl2_q;
    logic [PW-1:0]    p2_q;
    logic [TAG_W-1:0] tag2_q;
    logic             v3_q;
    logic [TW-1:0]    t3_q;
    logic [TAG_W-1:0] tag3_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] res_q;
    logic [TAG_W-1:0] otag_q;

    logic [ZW-1:0]    q1;
    logic [PW-1:0]    p2_d;
    logic [TW-1:0]    q3;
    logic [TW-1:0]    t3_d;
    logic [TW-1:0]    r_a;
    logic [WIDTH-1:0] res_d;

    assign adv        = !out_valid_q || out_ready;
    assign pipe_empty = !v1_q && !v2_q && !v3_q && !out_valid_q;
    assign calc_last  = (state_q == CALC) && (cnt_q == '0);
    assign cfg_done   = done_q;
    assign out_valid  = out_valid_q;
    assign out_result = res_q;
    assign out_tag    = otag_q;

    // Control outputs and next state; modulus changes only with an empty pipeline
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        busy      = 1'b0;
        in_ready  = 1'b0;
        case (state_q)
            UNCONF: cfg_ready = 1'b1;
            CALC:   busy      = 1'b1;
            READY: begin
                cfg_ready = pipe_empty;
                in_ready  = adv;
            end
            default: cfg_ready = 1'b0;
        endcase
        cfg_fire = cfg_valid && cfg_ready;
        case (state_q)
            UNCONF:  if (cfg_fire) state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = READY;
            READY:   if (cfg_fire) state_d = CALC;
            default: state_d = UNCONF;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= UNCONF;
        else        state_q <= state_d;
    end

    // Bit length of the incoming modulus
    always_comb begin
        k_new = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cfg_q[i]) k_new = KW'(i + 1);
        end
    end

    // One restoring-division step of 2^(2k) / q; the dividend has a single 1 at bit 2k
    always_comb begin
        rem_sh = {rem_q, (cnt_q == {k_q, 1'b0})};
        if (rem_sh >= {1'b0, q_q}) begin
            rem_d = WIDTH'(rem_sh - {1'b0, q_q});
            mu_d  = {mu_q[WIDTH-1:0], 1'b1};
        end else begin
            rem_d = rem_sh[WIDTH-1:0];
            mu_d  = {mu_q[WIDTH-1:0], 1'b0};
        end
    end

    // Modulus latch and mu computation, walking dividend bits 2*WIDTH down to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            k_q    <= '0;
            mu_q   <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= calc_last;
            if (cfg_fire) begin
                q_q   <= cfg_q;
                k_q   <= k_new;
                mu_q  <= '0;
                rem_q <= '0;
                cnt_q <= CNT_W'(2 * WIDTH);
            end else if (state_q == CALC) begin
                mu_q  <= mu_d;
                rem_q <= rem_d;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Barrett datapath between stages; t only needs WIDTH+2 bits since t < 3q
    always_comb begin
        q1    = z1_q >> (k_q - 1'b1);
        p2_d  = PW'(q1) * PW'(mu_q);
        q3    = TW'(p2_q >> ({1'b0, k_q} + 1'b1));
        t3_d  = zl2_q - q3 * TW'(q_q);
        r_a   = (t3_q >= TW'(q_q)) ? t3_q - TW'(q_q) : t3_q;
        res_d = (r_a >= TW'(q_q)) ? WIDTH'(r_a - TW'(q_q)) : WIDTH'(r_a);
    end

    // Four-register pipeline that advances as a whole only when the output can move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            z1_q        <= '0;
            tag1_q      <= '0;
            v2_q        <= 1'b0;
            zl2_q       <= '0;
            p2_q        <= '0;
            tag2_q      <= '0;
            v3_q        <= 1'b0;
            t3_q        <= '0;
            tag3_q      <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            otag_q      <= '0;
        end else if (adv) begin
            v1_q        <= in_valid && in_ready;
            z1_q        <= ZW'(in_a) * ZW'(in_b);
            tag1_q      <= in_tag;
            v2_q        <= v1_q;
            zl2_q       <= z1_q[TW-1:0];
            p2_q        <= p2_d;
            tag2_q      <= tag1_q;
            v3_q        <= v2_q;
            t3_q        <= t3_d;
            tag3_q      <= tag2_q;
            out_valid_q <= v3_q;
            res_q       <= res_d;
            otag_q      <= tag3_q;
        end
    end
endmodule

// File: tb/tb_barrett_modmul_pipe.sv
// tb/tb_barrett_modmul_pipe.sv - scoreboard bench for barrett_modmul_pipe
module tb_barrett_modmul_pipe;
    localparam int W  = 32;
    localparam int TG = 8;

    logic          clk;
    logic          rst_n;
    logic          cfg_valid;
    logic [W-1:0]  cfg_q;
    logic          cfg_ready;
    logic          cfg_done;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TG-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TG-1:0] out_tag;

    typedef struct {
        logic [W-1:0]  res;
        logic [TG-1:0] tag;
        int            cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    bit           rand_or = 0;
    bit           lat_chk = 0;
    bit           prev_stall = 0;
    logic [W-1:0] cur_q = 1;

    barrett_modmul_pipe #(.WIDTH(W), .TAG_W(TG)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_q(cfg_q), .cfg_ready(cfg_ready),
        .cfg_done(cfg_done), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: sampled 1 time unit before each rising edge
    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            sb.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) check_eq("hold_valid", out_valid, 1);
            if (out_valid) begin
                check_eq("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check_eq("result", out_result, sb[0].res);
                    check_eq("tag", out_tag, sb[0].tag);
                    if (out_ready) begin
                        if (lat_chk) check_eq("latency", cyc - sb[0].cyc, 4);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            if (in_valid && in_ready) begin
                e.res = W'((64'(in_a) * 64'(in_b)) % 64'(cur_q));
                e.tag = in_tag;
                e.cyc = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic chk_reset(input string s);
        check_eq({s, "_cfg_ready"}, cfg_ready, 1);
        check_eq({s, "_cfg_done"}, cfg_done, 0);
        check_eq({s, "_busy"}, busy, 0);
        check_eq({s, "_in_ready"}, in_ready, 0);
        check_eq({s, "_out_valid"}, out_valid, 0);
        check_eq({s, "_out_result"}, out_result, 0);
        check_eq({s, "_out_tag"}, out_tag, 0);
        check_eq({s, "_mu"}, dut.mu_q, 0);
        check_eq({s, "_k"}, dut.k_q, 0);
    endtask

    // Called and returns at a falling edge
    task automatic do_cfg(input logic [W-1:0] qv, input bit poke);
        int n;
        int busy_n;
        bit acc;
        cur_q = qv;
        cfg_valid = 1;
        cfg_q = qv;
        acc = 0;
        n = 0;
        while (!acc && n < 100) begin
            #4;
            acc = cfg_ready;
            @(negedge clk);
            n++;
        end
        cfg_valid = 0;
        check_eq("cfg_accept", acc, 1);
        busy_n = 0;
        n = 0;
        #4;
        while (!cfg_done && n < 200) begin
            if (busy) busy_n++;
            @(negedge clk);
            n++;
            if (poke && n == 5) begin
                cfg_valid = 1;
                cfg_q = qv - 1;
            end
            if (poke && n == 10) cfg_valid = 0;
            #4;
        end
        check_eq("busy_cycles", busy_n, 2 * W + 1);
        check_eq("cfg_done", cfg_done, 1);
        check_eq("in_ready_at_done", in_ready, 1);
        @(negedge clk);
        #4;
        check_eq("cfg_done_pulse", cfg_done, 0);
        check_eq("q_reg", dut.q_q, qv);
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TG-1:0] t);
        int n;
        bit acc;
        in_valid = 1;
        in_a = a;
        in_b = b;
        in_tag = t;
        acc = 0;
        n = 0;
        while (!acc && n < 1000) begin
            if (rand_or) out_ready = 1'($urandom_range(0, 1));
            #4;
            acc = in_ready;
            @(negedge clk);
            n++;
        end
        check_eq("in_accept", acc, 1);
    endtask

    task automatic drain();
        int n;
        in_valid = 0;
        out_ready = 1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drained", sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        cfg_valid = 0;
        cfg_q = 0;
        in_valid = 0;
        in_a = 0;
        in_b = 0;
        in_tag = 0;
        out_ready = 1;
        repeat (3) @(negedge clk);
        #4;
        chk_reset("por");
        @(negedge clk);
        rst_n = 1;

        do_cfg(32'd3329, 0);
        check_eq("mu_3329", dut.mu_q, 5039);
        check_eq("k_3329", dut.k_q, 12);

        lat_chk = 1;
        send(32'd3328, 32'd3328, 8'd1);
        send(32'd1234, 32'd2345, 8'd2);
        send(32'd0, 32'd3328, 8'd3);
        drain();

        do_cfg(32'd8380417, 0);
        send(32'd8380416, 32'd8380416, 8'h10);
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #4;
            check_eq("cfg_ready_in_flight", cfg_ready, 0);
            @(negedge clk);
        end
        drain();
        #4;
        check_eq("cfg_ready_empty", cfg_ready, 1);
        @(negedge clk);

        lat_chk = 0;
        rand_or = 1;
        for (int i = 0; i < 1000; i++) send($urandom % cur_q, $urandom % cur_q, 8'(i));
        rand_or = 0;
        drain();

        do_cfg(32'd3329, 0);
        out_ready = 0;
        for (int i = 0; i < 4; i++) send(32'(i + 5), 32'(i + 7), 8'(i + 40));
        in_valid = 0;
        #4;
        check_eq("stall_out_valid", out_valid, 1);
        check_eq("stall_in_ready", in_ready, 0);
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk_reset("rst_stream");
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        #4;
        check_eq("post_rst_stream_in_ready", in_ready, 0);
        @(negedge clk);

        cfg_valid = 1;
        cfg_q = 32'd12289;
        @(negedge clk);
        cfg_valid = 0;
        repeat (10) @(negedge clk);
        #4;
        check_eq("mid_calc_busy", busy, 1);
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk_reset("rst_calc");
        @(negedge clk);
        rst_n = 1;
        #4;
        check_eq("post_rst_calc_in_ready", in_ready, 0);
        check_eq("post_rst_calc_busy", busy, 0);
        @(negedge clk);

        lat_chk = 1;
        do_cfg(32'd2, 0);
        check_eq("mu_2", dut.mu_q, 8);
        check_eq("k_2", dut.k_q, 2);
        send(32'd1, 32'd1, 8'h21);
        send(32'd0, 32'd1, 8'h22);
        drain();

        do_cfg(32'hFFFF_FFFF, 1);
        check_eq("mu_max", dut.mu_q, 64'h1_0000_0001);
        check_eq("k_max", dut.k_q, 32);
        send(32'hFFFF_FFFE, 32'hFFFF_FFFE, 8'h31);
        send(32'hFFFF_FFFE, 32'h1234_5678, 8'h32);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
